// File: rtl/clic_irq_sink.sv
// Core-side receiver for the CLIC interrupt handshake: checks eligibility against hart state,
// offers an eligible interrupt as a trap request, returns the claim pulse and answers kills.
module clic_irq_sink #(
    parameter int unsigned N_SOURCE  = 256,
    parameter int unsigned PrioWidth = 8,
    parameter int unsigned ModeWidth = 2,
    parameter int unsigned VsidWidth = 6,
    parameter int unsigned CntWidth  = 16,
    localparam int unsigned SrcWidth = $clog2(N_SOURCE)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 irq_valid_i,
    output logic                 irq_ready_o,
    input  logic [SrcWidth-1:0]  irq_id_i,
    input  logic [PrioWidth-1:0] irq_level_i,
    input  logic [ModeWidth-1:0] irq_mode_i,
    input  logic                 irq_v_i,
    input  logic [VsidWidth-1:0] irq_vsid_i,
    input  logic                 irq_shv_i,
    input  logic                 irq_kill_req_i,
    output logic                 irq_kill_ack_o,
    input  logic [ModeWidth-1:0] priv_i,
    input  logic                 mie_i,
    input  logic                 sie_i,
    input  logic [PrioWidth-1:0] mil_i,
    input  logic [PrioWidth-1:0] mthresh_i,
    input  logic [PrioWidth-1:0] sil_i,
    input  logic [PrioWidth-1:0] sthresh_i,
    output logic                 trap_req_o,
    input  logic                 trap_ack_i,
    output logic [SrcWidth-1:0]  trap_id_o,
    output logic [PrioWidth-1:0] trap_level_o,
    output logic [ModeWidth-1:0] trap_mode_o,
    output logic                 trap_v_o,
    output logic [VsidWidth-1:0] trap_vsid_o,
    output logic                 trap_shv_o,
    output logic [CntWidth-1:0]  kill_cnt_o
);

    localparam logic [ModeWidth-1:0] ModeU = ModeWidth'(0);
    localparam logic [ModeWidth-1:0] ModeS = ModeWidth'(1);
    localparam logic [ModeWidth-1:0] ModeM = ModeWidth'(3);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_READY = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic                 elig;
    logic                 pend_hit;
    logic                 latch_en;
    logic                 cnt_inc;
    logic [PrioWidth-1:0] m_bar;
    logic [PrioWidth-1:0] s_bar;

    // Eligibility of the live request against the current hart state
    always_comb begin
        m_bar = (mil_i > mthresh_i) ? mil_i : mthresh_i;
        s_bar = (sil_i > sthresh_i) ? sil_i : sthresh_i;
        elig  = 1'b0;
        if (irq_mode_i == ModeM) begin
            if (priv_i != ModeM) begin
                elig = 1'b1;
            end else begin
                elig = mie_i && (irq_level_i > m_bar);
            end
        end else if (irq_mode_i == ModeS) begin
            if (priv_i == ModeU) begin
                elig = 1'b1;
            end else if (priv_i == ModeS) begin
                elig = sie_i && (irq_level_i > s_bar);
            end
        end
    end

    // A pending request stays offered only while the same interrupt remains valid and eligible
    assign pend_hit = (state_q == ST_PEND) && irq_valid_i && elig && (irq_id_i == trap_id_o);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        latch_en       = 1'b0;
        cnt_inc        = 1'b0;
        trap_req_o     = 1'b0;
        irq_kill_ack_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (irq_kill_req_i) begin
                    irq_kill_ack_o = 1'b1;
                end else if (irq_valid_i && elig) begin
                    latch_en = 1'b1;
                    state_d  = ST_PEND;
                end
            end
            ST_PEND: begin
                trap_req_o = pend_hit;
                // Commit wins over a simultaneous kill
                if (pend_hit && trap_ack_i) begin
                    state_d = ST_READY;
                end else if (irq_kill_req_i) begin
                    irq_kill_ack_o = 1'b1;
                    cnt_inc        = 1'b1;
                    state_d        = ST_IDLE;
                end else if (!pend_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_READY: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign irq_ready_o = (state_q == ST_READY);

    // Trap information captured on acceptance, held until the next acceptance
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trap_id_o    <= '0;
            trap_level_o <= '0;
            trap_mode_o  <= '0;
            trap_v_o     <= 1'b0;
            trap_vsid_o  <= '0;
            trap_shv_o   <= 1'b0;
        end else if (latch_en) begin
            trap_id_o    <= irq_id_i;
            trap_level_o <= irq_level_i;
            trap_mode_o  <= irq_mode_i;
            trap_v_o     <= irq_v_i;
            trap_vsid_o  <= irq_vsid_i;
            trap_shv_o   <= irq_shv_i;
        end
    end

    // Saturating count of kills that withdrew a pending request
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            kill_cnt_o <= '0;
        end else if (cnt_inc && (kill_cnt_o != {CntWidth{1'b1}})) begin
            kill_cnt_o <= kill_cnt_o + CntWidth'(1);
        end
    end

endmodule
